dffram_arbiter: RTL and testbench
=================================

Name: dffram_arbiter

Overview:
- Shares one single-port DFFRAM macro (4096 x 32, byte write mask, 1-cycle synchronous read) between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Each requester gets a req/gnt/rvalid interface.
- Arbitrates one access per cycle, decodes byte addresses to the RAM word address, and returns read data and error status one cycle after grant.
- Sits between the core's memory ports and the DFFRAM instance.

Parameters:
- AW, 12, RAM word-address width (depth = 2**AW words)
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window
- MAX_WAIT, 4, consecutive cycles the instruction port may be denied before it is forced to win (fixed-priority mode only)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- if_req_i  in  1  instruction request
- if_addr_i  in  32  instruction byte address
- if_gnt_o  out  1  instruction request accepted this cycle
- if_rvalid_o  out  1  instruction response valid
- if_rdata_o  out  32  instruction read data
- if_err_o  out  1  instruction response error (qualified by if_rvalid_o)
- d_req_i  in  1  data request
- d_we_i  in  1  data write enable
- d_be_i  in  4  data byte enables
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  data write data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  32  data read data
- d_err_o  out  1  data response error
- ram_en_o  out  1  to DFFRAM EN
- ram_we_o  out  4  to DFFRAM WE
- ram_di_o  out  32  to DFFRAM DI
- ram_a_o  out  AW  to DFFRAM A
- ram_do_i  in  32  from DFFRAM DO

Behaviour:
- Reset state:
  - all gnt/rvalid/err outputs 0; rdata outputs 32'h0.
  - ram_en_o = 0, ram_we_o = 0.
  - starvation counter = 0; round-robin pointer = instruction.
- Grants are combinational from req in the same cycle; at most one grant per cycle.
- Requester handshake:
  - The requester holds req and its payload stable until it sees gnt.
  - After gnt it may drop req or issue a new request next cycle (back-to-back accesses are allowed).
- Address decode:
  - in-range iff (addr - BASE_ADDR) < 4 * 2**AW.
  - word address = (addr - BASE_ADDR) >> 2; bits [1:0] are ignored.
- Granted in-range access:
  - ram_en_o = 1; ram_a_o = word address.
  - ram_we_o = d_be_i when d_we_i = 1, else 4'b0. Instruction accesses always have ram_we_o = 0.
  - ram_di_o = d_wdata_i.
- Granted out-of-range access:
  - ram_en_o = 0 (the RAM is not touched).
  - The request is still granted, and the response carries err = 1, rdata = 0.
- Response:
  - registered owner/err flags; rvalid asserts exactly one cycle after gnt, for one cycle, on the granted port only.
  - rdata = ram_do_i on reads; rdata = 0 on writes and on errors.
  - Writes also produce an rvalid (write acknowledge).
- Arbitration, fixed priority (default):
  - data wins over instruction.
  - Starvation counter increments each cycle if_req_i = 1 and is not granted; it clears when the instruction port is granted or if_req_i = 0.
  - When the counter reaches MAX_WAIT, the instruction port wins the next contest.
- Simultaneous requests with no prior pending: data granted, instruction gnt = 0.
- Idle cycles (no req): ram_en_o = 0, no rvalid the next cycle.
- Reset asserted mid-access: the pending response is discarded (no rvalid after reset). The RAM content is not reset.
- Unused data byte enables with d_we_i = 1 and d_be_i = 4'b0: granted, no RAM byte written, ack rvalid.

Optional Feature:
- Macro DFFRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On contention, the port not granted most recently wins; the pointer updates only on a contested grant.
  - The starvation counter and MAX_WAIT are unused and removed.
- Undefined: fixed priority with the starvation counter, as described under Behaviour.

Decomposition:
- Package dffram_arb_pkg holds:
  - port-index enum (PORT_IF, PORT_D)
  - response struct {valid, err, owner}
  - default BASE_ADDR/AW localparams
- One sub-module, dffram_arb_decode: combinational address range check and word-address computation, instantiated once per port.

Test Plan:
- Data write then read:
  - stimulus: d write addr 0x10, be 4'b1111, wdata 0xDEADBEEF; read 0x10 next cycle.
  - response: ram_a_o = 4, gnt same cycle; rvalid one cycle later; d_rdata_o = 0xDEADBEEF.
- Byte mask:
  - stimulus: write 0xAABBCCDD to addr 0x20 with be 4'b1111, then 0x11223344 with be 4'b0101, then read.
  - response: 0xAA22CC44.
- Contention, fixed priority:
  - stimulus: both req held continuously.
  - response: d_gnt_o for 4 cycles, then if_gnt_o in the 5th (MAX_WAIT = 4); never two grants in one cycle.
- Round-robin build (DFFRAM_ARB_RR_EN):
  - stimulus: both req held.
  - response: grants alternate if, d, if, d starting with if after reset.
- Out-of-range:
  - stimulus: if read at BASE_ADDR + 0x4000.
  - response: if_gnt_o = 1, ram_en_o = 0; next cycle if_rvalid_o = 1, if_err_o = 1, if_rdata_o = 0.
- Reset mid-access:
  - stimulus: assert RST in the cycle after d_gnt_o.
  - response: d_rvalid_o stays 0; all outputs at reset values while RST = 1.

Source files
------------

// File: rtl/dffram_arb_pkg.sv
// Shared types and defaults for the DFFRAM two-port arbiter.
package dffram_arb_pkg;

  localparam int unsigned DEF_AW        = 12;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    logic  err;
    port_e owner;
  } resp_t;

endpackage

// File: rtl/dffram_arb_decode.sv
// Byte-address window check and RAM word-address extraction for one port.
module dffram_arb_decode
  import dffram_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic [31:0]   addr,
  output logic          in_range,
  output logic [AW-1:0] word_addr
);

  logic [31:0] offset;
  logic [32:0] limit;

  // Compare in 33 bits so the window size cannot overflow for large AW.
  assign offset    = addr - BASE_ADDR;
  assign limit     = 33'd4 << AW;
  assign in_range  = ({1'b0, offset} < limit);
  assign word_addr = offset[AW+1:2];

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between instruction fetch and data ports.
// Build option: DFFRAM_ARB_RR_EN selects round-robin arbitration instead of
// fixed data priority with an instruction starvation counter.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_di_o,
  output logic [AW-1:0] ram_a_o,
  input  logic [31:0]   ram_do_i
);

  logic          if_in_range, d_in_range;
  logic [AW-1:0] if_word, d_word;
  logic          if_gnt, d_gnt;
  resp_t         resp_q;
  logic          rd_q;

  dffram_arb_decode #(
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_if_dec (
    .addr      (if_addr_i),
    .in_range  (if_in_range),
    .word_addr (if_word)
  );

  dffram_arb_decode #(
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_d_dec (
    .addr      (d_addr_i),
    .in_range  (d_in_range),
    .word_addr (d_word)
  );

`ifdef DFFRAM_ARB_RR_EN
  port_e rr_ptr_q;

  // Priority pointer: moves to the loser only after a contested grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q <= PORT_IF;
    end else if (if_req_i && d_req_i) begin
      rr_ptr_q <= if_gnt ? PORT_D : PORT_IF;
    end
  end
`else
  localparam int unsigned CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic [CW-1:0] starve_q;

  // Counts consecutive denied instruction cycles; cleared on grant or idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q <= '0;
    end else if (if_req_i && !if_gnt) begin
      starve_q <= starve_q + 1'b1;
    end else begin
      starve_q <= '0;
    end
  end
`endif

  // Single-grant arbitration; grants are suppressed while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!RST) begin
      if (if_req_i && d_req_i) begin
`ifdef DFFRAM_ARB_RR_EN
        if (rr_ptr_q == PORT_IF) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
`else
        if (starve_q >= WAIT_LIM) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
`endif
      end else begin
        if_gnt = if_req_i;
        d_gnt  = d_req_i;
      end
    end
  end

  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;
  assign ram_di_o = d_wdata_i;

  // Steer the winning port onto the RAM; out-of-range accesses leave it idle.
  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = '0;
    ram_a_o  = '0;
    if (d_gnt) begin
      ram_a_o = d_word;
      if (d_in_range) begin
        ram_en_o = 1'b1;
        ram_we_o = d_we_i ? d_be_i : 4'b0000;
      end
    end else if (if_gnt) begin
      ram_a_o = if_word;
      if (if_in_range) begin
        ram_en_o = 1'b1;
      end
    end
  end

  // Response tracking: one registered entry, valid the cycle after grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      resp_q.valid <= if_gnt | d_gnt;
      resp_q.err   <= d_gnt ? !d_in_range : !if_in_range;
      resp_q.owner <= d_gnt ? PORT_D : PORT_IF;
      rd_q         <= d_gnt ? !d_we_i : 1'b1;
    end
  end

  assign if_rvalid_o = resp_q.valid && (resp_q.owner == PORT_IF);
  assign d_rvalid_o  = resp_q.valid && (resp_q.owner == PORT_D);
  assign if_err_o    = if_rvalid_o && resp_q.err;
  assign d_err_o     = d_rvalid_o && resp_q.err;
  assign if_rdata_o  = (if_rvalid_o && !resp_q.err && rd_q) ? ram_do_i : '0;
  assign d_rdata_o   = (d_rvalid_o && !resp_q.err && rd_q) ? ram_do_i : '0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural DFFRAM model.
module tb_dffram_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_di_o;
  logic [11:0] ram_a_o;
  logic [31:0] ram_do_i;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dffram_arbiter #(
    .AW        (12),
    .BASE_ADDR (32'h0000_0000),
    .MAX_WAIT  (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_be_i      (d_be_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .d_err_o     (d_err_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_di_o    (ram_di_o),
    .ram_a_o     (ram_a_o),
    .ram_do_i    (ram_do_i)
  );

  // DFFRAM model: byte-masked write, registered read.
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    ram_do_i = 32'h0;
  end
  always @(posedge CLK) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
      ram_do_i <= mem[ram_a_o];
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] dw);
    if_req_i  = ir;
    if_addr_i = ia;
    d_req_i   = dr;
    d_we_i    = dwe;
    d_be_i    = be;
    d_addr_i  = da;
    d_wdata_i = dw;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge CLK); #1;
    checks++; if (if_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt_o); end
    checks++; if (d_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt_o); end
    checks++; if (ram_en_o !== 1'b0 || ram_we_o !== 4'h0) begin errors++; $display("FAIL reset_ram: en %b we %h want 0 0", ram_en_o, ram_we_o); end
    checks++; if ({if_rvalid_o, d_rvalid_o, if_err_o, d_err_o} !== 4'b0) begin errors++; $display("FAIL reset_resp: got %b want 0000", {if_rvalid_o, d_rvalid_o, if_err_o, d_err_o}); end
    checks++; if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: if %h d %h want 0", if_rdata_o, d_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    RST = 1'b0;
  endtask

  task automatic test_write_read;
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    #1;
    checks++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL wr_gnt: d %b if %b want 1 0", d_gnt_o, if_gnt_o); end
    checks++; if (ram_en_o !== 1'b1 || ram_a_o !== 12'd4) begin errors++; $display("FAIL wr_ram_addr: en %b a %h want 1 004", ram_en_o, ram_a_o); end
    checks++; if (ram_we_o !== 4'hF || ram_di_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram_data: we %h di %h want f deadbeef", ram_we_o, ram_di_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_ack: rv %b err %b rd %h want 1 0 0", d_rvalid_o, d_err_o, d_rdata_o); end
    checks++; if (if_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_ack_if: got %b want 0", if_rvalid_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    checks++; if (d_gnt_o !== 1'b1 || ram_we_o !== 4'h0 || ram_a_o !== 12'd4) begin errors++; $display("FAIL rd_req: gnt %b we %h a %h want 1 0 004", d_gnt_o, ram_we_o, ram_a_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: rv %b rd %h want 1 deadbeef", d_rvalid_o, d_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++; if (ram_en_o !== 1'b0 || d_gnt_o !== 1'b0 || if_gnt_o !== 1'b0) begin errors++; $display("FAIL idle_ram: en %b gnt %b%b want 0 00", ram_en_o, d_gnt_o, if_gnt_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0) begin errors++; $display("FAIL idle_rvalid: d %b if %b want 0 0", d_rvalid_o, if_rvalid_o); end
  endtask

  task automatic test_byte_mask;
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
    #1;
    checks++; if (ram_we_o !== 4'b0101 || ram_a_o !== 12'd8) begin errors++; $display("FAIL mask_we: we %b a %h want 0101 008", ram_we_o, ram_a_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h23, 32'h0);
    #1;
    checks++; if (ram_a_o !== 12'd8) begin errors++; $display("FAIL mask_lowbits: a %h want 008", ram_a_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hAA22_CC44) begin errors++; $display("FAIL mask_data: rv %b rd %h want 1 aa22cc44", d_rvalid_o, d_rdata_o); end
  endtask

  task automatic test_zero_be;
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
    #1;
    checks++; if (d_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 4'h0) begin errors++; $display("FAIL zbe_req: gnt %b en %b we %h want 1 1 0", d_gnt_o, ram_en_o, ram_we_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL zbe_ack: rv %b err %b rd %h want 1 0 0", d_rvalid_o, d_err_o, d_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    @(posedge CLK); #1;
    checks++; if (d_rdata_o !== 32'hAA22_CC44) begin errors++; $display("FAIL zbe_data: rd %h want aa22cc44", d_rdata_o); end
  endtask

  task automatic test_if_read;
    @(negedge CLK);
    drive(1'b1, 32'h10, 1'b0, 1'b1, 4'hF, 32'h20, 32'h5555_5555);
    #1;
    checks++; if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0 || ram_en_o !== 1'b1) begin errors++; $display("FAIL if_req: gnt %b d %b en %b want 1 0 1", if_gnt_o, d_gnt_o, ram_en_o); end
    checks++; if (ram_we_o !== 4'h0 || ram_a_o !== 12'd4) begin errors++; $display("FAIL if_ram: we %h a %h want 0 004", ram_we_o, ram_a_o); end
    @(posedge CLK); #1;
    checks++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hDEAD_BEEF || if_err_o !== 1'b0) begin errors++; $display("FAIL if_data: rv %b rd %h err %b want 1 deadbeef 0", if_rvalid_o, if_rdata_o, if_err_o); end
    checks++; if (d_rvalid_o !== 1'b0) begin errors++; $display("FAIL if_no_d: got %b want 0", d_rvalid_o); end
  endtask

  task automatic test_out_of_range;
    @(negedge CLK);
    drive(1'b1, 32'h0000_4000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++; if (if_gnt_o !== 1'b1 || ram_en_o !== 1'b0) begin errors++; $display("FAIL oor_if_req: gnt %b en %b want 1 0", if_gnt_o, ram_en_o); end
    @(posedge CLK); #1;
    checks++; if (if_rvalid_o !== 1'b1 || if_err_o !== 1'b1 || if_rdata_o !== 32'h0) begin errors++; $display("FAIL oor_if_resp: rv %b err %b rd %h want 1 1 0", if_rvalid_o, if_err_o, if_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678);
    #1;
    checks++; if (d_gnt_o !== 1'b1 || ram_en_o !== 1'b0 || ram_we_o !== 4'h0) begin errors++; $display("FAIL oor_d_req: gnt %b en %b we %h want 1 0 0", d_gnt_o, ram_en_o, ram_we_o); end
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_err_o !== 1'b1 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL oor_d_resp: rv %b err %b rd %h want 1 1 0", d_rvalid_o, d_err_o, d_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_contention;
    logic expd;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
`ifdef DFFRAM_ARB_RR_EN
      expd = (i % 2) == 1;
`else
      expd = (i % 5) != 4;
`endif
      checks++; if (d_gnt_o !== expd || if_gnt_o !== !expd) begin errors++; $display("FAIL cont_gnt[%0d]: d %b if %b want %b %b", i, d_gnt_o, if_gnt_o, expd, !expd); end
      checks++; if (ram_a_o !== (expd ? 12'd8 : 12'd4)) begin errors++; $display("FAIL cont_addr[%0d]: a %h want %h", i, ram_a_o, expd ? 12'd8 : 12'd4); end
      @(posedge CLK); #1;
      checks++; if (d_rvalid_o !== expd || if_rvalid_o !== !expd) begin errors++; $display("FAIL cont_rv[%0d]: d %b if %b want %b %b", i, d_rvalid_o, if_rvalid_o, expd, !expd); end
      checks++; if ((expd ? d_rdata_o : if_rdata_o) !== (expd ? 32'hAA22_CC44 : 32'hDEAD_BEEF)) begin errors++; $display("FAIL cont_data[%0d]: d %h if %h", i, d_rdata_o, if_rdata_o); end
    end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", d_gnt_o); end
    @(posedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin errors++; $display("FAIL rmid_resp: rv %b rd %h want 0 0", d_rvalid_o, d_rdata_o); end
    checks++; if (d_gnt_o !== 1'b0 || ram_en_o !== 1'b0 || ram_we_o !== 4'h0) begin errors++; $display("FAIL rmid_outs: gnt %b en %b we %h want 0 0 0", d_gnt_o, ram_en_o, ram_we_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b0) begin errors++; $display("FAIL rmid_after: rv %b want 0", d_rvalid_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge CLK); #1;
    checks++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmid_mem: rv %b rd %h want 1 deadbeef", d_rvalid_o, d_rdata_o); end
    @(negedge CLK);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_zero_be();
    test_if_read();
    test_out_of_range();
    test_contention();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
